// File: rtl/display_scan_if.sv
// display_scan_if
//   Bundles the scan controller's control, data and display-side signals.
//   master : the side that drives en/digits and observes the display outputs.
//   slave  : the scan controller itself.
//   Signals:
//     en         scan enable (low forces the display dark)
//     digits     16-bit BCD word, [3:0] = rightmost digit
//     bcd_out    nibble for the shared BCD-to-segment decoder (4'hF = blank)
//     anode      active-low digit enables, anode[i] drives digit i
//     frame_tick one-cycle pulse when a new frame snapshot is taken
interface display_scan_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;
  logic        frame_tick;

  modport master (
    output en,
    output digits,
    input  bcd_out,
    input  anode,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  digits,
    output bcd_out,
    output anode,
    output frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display sharing one BCD-to-segment decoder. Each digit gets a dwell of
//   REFRESH_DIV cycles: BLANK_CYCLES with all anodes off (decoder input is
//   pre-settled to suppress ghosting), then the rest with that digit's anode
//   low. The BCD word is snapshotted once per frame so a mid-frame change
//   never tears the display.
//
//   Parameters:
//     REFRESH_DIV  cycles per digit dwell (blank + show), > BLANK_CYCLES
//     BLANK_CYCLES blank cycles at the start of each dwell, >= 1
//
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  display_scan_if.slave (en, digits in; bcd_out, anode, frame_tick out)
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When defined, leading zeros of the snapshot (digits 3..1) are output as
//     4'hF (blank). Digit 0 is never suppressed; anode timing is unchanged.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   snap_reg, snap_next;
  logic [3:0]    anode_reg, anode_next;
  logic [3:0]    bcd_reg, bcd_next;
  logic          tick_reg, tick_next;

  // Per-digit value as it should reach the decoder, derived from the
  // snapshot that will be in effect after this edge.
  logic [3:0] shown [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] nib;
    assign nib = snap_next[4*gi +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (gi == 0) begin : g_keep
      assign shown[gi] = nib;
    end else begin : g_lz
      // Blank when this digit and every digit to its left are zero.
      assign shown[gi] = (snap_next[15:4*gi] == '0) ? 4'hF : nib;
    end
`else
    assign shown[gi] = nib;
`endif
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      snap_reg  <= '0;
      anode_reg <= 4'b1111;
      bcd_reg   <= 4'hF;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      snap_reg  <= snap_next;
      anode_reg <= anode_next;
      bcd_reg   <= bcd_next;
      tick_reg  <= tick_next;
    end
  end

  // Next-state logic. The dwell counter runs 0..REFRESH_DIV-1 across both
  // BLANK and SHOW, so the blank/show split is a compare, not a reload.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    snap_next  = snap_reg;
    tick_next  = 1'b0;

    if (!bus.en) begin
      // Disable has priority over any dwell/frame boundary on the same edge.
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = '0;
          snap_next  = bus.digits;
          tick_next  = 1'b1;
        end
        BLANK: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == BLANK_LAST) begin
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              snap_next = bus.digits;
              tick_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs are registered yet aligned
  // with the state they describe.
  always_comb begin
    anode_next = 4'b1111;
    bcd_next   = 4'hF;
    unique case (state_next)
      BLANK: begin
        bcd_next = shown[idx_next];
      end
      SHOW: begin
        anode_next = ~(4'b0001 << idx_next);
        bcd_next   = shown[idx_next];
      end
      default: begin
        anode_next = 4'b1111;
        bcd_next   = 4'hF;
      end
    endcase
  end

  assign bus.anode      = anode_reg;
  assign bus.bcd_out    = bcd_reg;
  assign bus.frame_tick = tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed, table-driven bench for display_scan_ctrl with REFRESH_DIV=8,
//   BLANK_CYCLES=2. Each table record sets en/digits, advances a number of
//   clocks, then compares anode, bcd_out and frame_tick. Hand-written
//   sequences cover power-on reset, asynchronous reset mid-scan and
//   frame_tick spacing.
module tb_display_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  typedef struct {
    logic        en;
    logic [15:0] digits;
    int          n;
    logic [3:0]  anode;
    logic [3:0]  bcd;
    logic        tick;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  display_scan_if bus ();

  display_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an, input logic [3:0] bcd,
                           input logic tk);
    check({tag, ".anode"}, {12'h0, bus.anode}, {12'h0, an});
    check({tag, ".bcd_out"}, {12'h0, bus.bcd_out}, {12'h0, bcd});
    check({tag, ".frame_tick"}, {15'h0, bus.frame_tick}, {15'h0, tk});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    int gap;
    bit seen;

    // Hand-computed vectors; E = edge that first samples en=1 from IDLE.
    vecs.push_back('{1'b1, 16'h1234, 1, 4'b1111, 4'h4, 1'b1}); // E: BLANK d0, tick
    vecs.push_back('{1'b1, 16'h1234, 1, 4'b1111, 4'h4, 1'b0}); // E+1 still blank
    vecs.push_back('{1'b1, 16'h1234, 1, 4'b1110, 4'h4, 1'b0}); // E+2 SHOW d0
    vecs.push_back('{1'b1, 16'h1234, 5, 4'b1110, 4'h4, 1'b0}); // E+7 last of dwell
    vecs.push_back('{1'b1, 16'h1234, 1, 4'b1111, 4'h3, 1'b0}); // E+8 BLANK d1
    vecs.push_back('{1'b1, 16'h1234, 2, 4'b1101, 4'h3, 1'b0}); // E+10 SHOW d1
    vecs.push_back('{1'b1, 16'h1234, 3, 4'b1101, 4'h3, 1'b0}); // E+13
    vecs.push_back('{1'b1, 16'h5678, 3, 4'b1111, 4'h2, 1'b0}); // E+16 old snapshot
    vecs.push_back('{1'b1, 16'h5678, 2, 4'b1011, 4'h2, 1'b0}); // E+18 SHOW d2
    vecs.push_back('{1'b1, 16'h5678, 6, 4'b1111, 4'h1, 1'b0}); // E+24 BLANK d3
    vecs.push_back('{1'b1, 16'h5678, 2, 4'b0111, 4'h1, 1'b0}); // E+26 SHOW d3
    vecs.push_back('{1'b1, 16'h5678, 6, 4'b1111, 4'h8, 1'b1}); // E+32 new frame
    vecs.push_back('{1'b1, 16'h5678, 1, 4'b1111, 4'h8, 1'b0}); // E+33
    vecs.push_back('{1'b1, 16'h5678, 7, 4'b1111, 4'h7, 1'b0}); // E+40 BLANK d1
    vecs.push_back('{1'b1, 16'h5678, 7, 4'b1101, 4'h7, 1'b0}); // E+47 end of d1
    vecs.push_back('{1'b0, 16'h5678, 1, 4'b1111, 4'hF, 1'b0}); // en=0 at d2 boundary
    vecs.push_back('{1'b0, 16'h5678, 3, 4'b1111, 4'hF, 1'b0}); // stays IDLE
    vecs.push_back('{1'b1, 16'hA0B9, 1, 4'b1111, 4'h9, 1'b1}); // restart at d0
    vecs.push_back('{1'b1, 16'hA0B9, 2, 4'b1110, 4'h9, 1'b0});
    vecs.push_back('{1'b1, 16'hA0B9, 6, 4'b1111, 4'hB, 1'b0});
    vecs.push_back('{1'b1, 16'hA0B9, 8, 4'b1111, 4'h0, 1'b0});
    vecs.push_back('{1'b1, 16'hA0B9, 8, 4'b1111, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 16'hA0B9, 2, 4'b0111, 4'hA, 1'b0});
    vecs.push_back('{1'b1, 16'hA0B9, 6, 4'b1111, 4'h9, 1'b1}); // frame wrap
    vecs.push_back('{1'b0, 16'h0040, 1, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{1'b1, 16'h0040, 1, 4'b1111, 4'h0, 1'b1});
    vecs.push_back('{1'b1, 16'h0040, 8, 4'b1111, 4'h4, 1'b0});
    vecs.push_back('{1'b1, 16'h0040, 8, 4'b1111, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0040, 2, 4'b1011, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0040, 6, 4'b1111, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0040, 2, 4'b0111, LZ,   1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1, 4'b1111, 4'hF, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 1, 4'b1111, 4'h0, 1'b1});
    vecs.push_back('{1'b1, 16'h0000, 8, 4'b1111, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0000, 8, 4'b1111, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0000, 8, 4'b1111, LZ,   1'b0});
    vecs.push_back('{1'b1, 16'h0000, 2, 4'b0111, LZ,   1'b0});

    // Power-on reset.
    bus.en     = 1'b0;
    bus.digits = 16'h0000;
    rst        = 1'b1;
    step(2);
    check_out("reset", 4'b1111, 4'hF, 1'b0);
    $display("[TB] reset: anode=%b bcd=%h tick=%b", bus.anode, bus.bcd_out, bus.frame_tick);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.en     = vecs[i].en;
      bus.digits = vecs[i].digits;
      step(vecs[i].n);
      check_out($sformatf("vec%0d", i), vecs[i].anode, vecs[i].bcd, vecs[i].tick);
      $display("[TB] vec %0d: en=%b digits=%h +%0d clk anode=%b bcd=%h tick=%b", i,
               vecs[i].en, vecs[i].digits, vecs[i].n, bus.anode, bus.bcd_out, bus.frame_tick);
    end

    // Asynchronous reset mid-SHOW (currently digit 3 SHOW): outputs must clear
    // before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_out("async_rst", 4'b1111, 4'hF, 1'b0);
    $display("[TB] async rst: anode=%b bcd=%h tick=%b", bus.anode, bus.bcd_out, bus.frame_tick);
    @(negedge clk);
    check_out("rst_held", 4'b1111, 4'hF, 1'b0);
    rst        = 1'b0;
    bus.en     = 1'b1;
    bus.digits = 16'h1234;
    step(1);
    check_out("rst_release", 4'b1111, 4'h4, 1'b1);
    step(2);
    check_out("rst_show", 4'b1110, 4'h4, 1'b0);
    $display("[TB] restart after rst: anode=%b bcd=%h", bus.anode, bus.bcd_out);

    // Next frame_tick must arrive 30 clocks later (frame = 32 from E, now E+2).
    gap  = 0;
    seen = 1'b0;
    while (!seen && gap < 4 * RD + 16) begin
      step(1);
      gap++;
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    check("tick_seen", {15'h0, seen}, 16'h0001);
    check("tick_gap", 16'(gap), 16'(4 * RD - 2));
    $display("[TB] frame_tick gap: %0d clocks", gap);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
